// File: rtl/flit_group_tx.sv
// Gathers one flit per compass port into an aligned 4-flit group for the pipeline stage.
// Partial groups are forced out after TIMEOUT cycles, and missing slots read as null flits.
module flit_group_tx #(
    parameter int FW      = 11,
    parameter int TIMEOUT = 4,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [FW-1:0] n_in,
    input  logic [FW-1:0] s_in,
    input  logic [FW-1:0] e_in,
    input  logic [FW-1:0] w_in,
    input  logic          n_vld,
    input  logic          s_vld,
    input  logic          e_vld,
    input  logic          w_vld,
    output logic          n_rdy,
    output logic          s_rdy,
    output logic          e_rdy,
    output logic          w_rdy,
    output logic [FW-1:0] nty,
    output logic [FW-1:0] sty,
    output logic [FW-1:0] ety,
    output logic [FW-1:0] wty,
    output logic          grp_vld,
    input  logic          grp_rdy,
    output logic [CW-1:0] grp_cnt
);

    typedef enum logic [1:0] {IDLE, COLLECT, LAUNCH} state_t;

    state_t        state, state_nx;
    logic [FW-1:0] slot [4];
    logic [FW-1:0] din  [4];
    logic [3:0]    filled, vld, rdy, store, fnext;
    logic [7:0]    timer, timer_nx;
    logic          hs;

    assign din[0] = n_in;
    assign din[1] = s_in;
    assign din[2] = e_in;
    assign din[3] = w_in;
    assign vld    = {w_vld, e_vld, s_vld, n_vld};

    // rdy depends only on registers (and reset), never on the inputs
    assign rdy = {4{rst_n & (state != LAUNCH)}} & ~filled;
    assign {w_rdy, e_rdy, s_rdy, n_rdy} = rdy;

    always_comb begin
        store = '0;
        for (int p = 0; p < 4; p++)
            store[p] = vld[p] & rdy[p] & din[p][FW-1];
    end

    assign fnext = filled | store;
    assign hs    = (state == LAUNCH) & grp_rdy;

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        case (state)
            IDLE: begin
                if (fnext == 4'hF) begin
                    state_nx = LAUNCH;
                end else if (fnext != 4'h0) begin
                    state_nx = COLLECT;
                    timer_nx = 8'd0;
                end
            end
            COLLECT: begin
                if (fnext == 4'hF)
                    state_nx = LAUNCH;
                else if (timer == 8'(TIMEOUT - 1) && fnext != 4'h0)
                    state_nx = LAUNCH;
                else
                    timer_nx = timer + 8'd1;
            end
            LAUNCH: begin
                if (grp_rdy)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= 8'd0;
            filled  <= 4'h0;
            grp_cnt <= '0;
            for (int p = 0; p < 4; p++)
                slot[p] <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            if (hs) begin
                // Clearing the slots here is what makes unfilled slots launch as null flits
                filled  <= 4'h0;
                grp_cnt <= grp_cnt + CW'(1);
                for (int p = 0; p < 4; p++)
                    slot[p] <= '0;
            end else begin
                filled <= fnext;
                for (int p = 0; p < 4; p++)
                    if (store[p])
                        slot[p] <= din[p];
            end
        end
    end

    assign grp_vld = (state == LAUNCH);
    assign nty     = grp_vld ? slot[0] : '0;
    assign sty     = grp_vld ? slot[1] : '0;
    assign ety     = grp_vld ? slot[2] : '0;
    assign wty     = grp_vld ? slot[3] : '0;

endmodule

// File: doc/flit_group_tx.md
Name: flit_group_tx

Overview:
- Transmit-side feeder for the router's four-port pipeline stage.
- Collects one flit from each of the north, south, east and west input links, then launches them as one aligned 4-flit group onto the stage's nty/sty/ety/wty inputs.
- Uses a valid/ready handshake on each input link and on the group output.
- Partially filled groups are launched after a timeout, with empty slots padded with null flits.

Parameters:
- FW, 11, flit width; bit FW-1 is the flit-valid flag.
- TIMEOUT, 4, cycles a partial group may wait in COLLECT before forced launch; legal range 1..255.
- CW, 8, width of the launched-group counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- n_in, s_in, e_in, w_in  in  FW each  per-port input flit.
- n_vld, s_vld, e_vld, w_vld  in  1 each  input flit valid.
- n_rdy, s_rdy, e_rdy, w_rdy  out  1 each  port can accept a flit this cycle.
- nty, sty, ety, wty  out  FW each  group flits to the pipeline stage.
- grp_vld  out  1  group presented on nty..wty.
- grp_rdy  in  1  pipeline stage accepts the group.
- grp_cnt  out  CW  count of launched groups, wraps.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-low (rst_n).
  - While rst_n=0: state=IDLE, slots=0, filled=4'b0, timer=0, grp_cnt=0, grp_vld=0, nty..wty=0, all *_rdy=0.
  - Reset takes effect immediately, mid-group included, and any in-progress group is discarded.
- State: IDLE, COLLECT, LAUNCH. Per-port slot register and filled bit, ordered {w,e,s,n}. timer is 8 bits.
- Ready: p_rdy = rst_n & (state!=LAUNCH) & ~filled[p]. This is combinational from registers only; there is no input-to-rdy path.
- Accept: acc[p] = p_vld & p_rdy.
  - If in[FW-1]=1, the slot is loaded and filled[p] is set.
  - If in[FW-1]=0, the flit is consumed and dropped; slot and filled are unchanged.
- Transitions at each edge, with fnext = filled | stored-accepts:
  - From IDLE or COLLECT with fnext==4'hF: go to LAUNCH.
  - From COLLECT with timer==TIMEOUT-1 and fnext!=0: go to LAUNCH.
  - From IDLE with fnext!=0: go to COLLECT, timer=0.
  - From COLLECT otherwise: stay, timer+1.
  - From IDLE with fnext==0: stay IDLE.
  - In LAUNCH, grp_vld&grp_rdy: go to IDLE, clear all slots and filled bits to 0, grp_cnt+1 (mod 2^CW).
  - In LAUNCH, grp_vld&~grp_rdy: hold.
- Outputs:
  - grp_vld = (state==LAUNCH), registered.
  - nty..wty = slot values in LAUNCH, otherwise all-zero. Unfilled slots read 0 (null flit).
  - While grp_vld=1 and grp_rdy=0, nty..wty are stable.
- Latency:
  - All four accepted at edge t: grp_vld=1 after edge t. The group is visible the cycle after the last accept.
  - Partial group: the first accept at edge t triggers launch at edge t+TIMEOUT.
- Simultaneous events:
  - No input is accepted in the handshake cycle, because rdy is low in LAUNCH.
  - Inputs may be accepted from the first IDLE cycle after the handshake.
- Back-to-back: the minimum group period is 2 cycles (accept, launch+handshake).
- Input-side flit reordering is not performed; each port's flit always lands in its own slot.

Test Plan:
1. Full group: after reset, one cycle with n/s/e/w_in=11'h401/402/403/404, all vld=1, grp_rdy=1 -> next cycle grp_vld=1, nty..wty=401/402/403/404. The following cycle has grp_vld=0, grp_cnt=1, all *_rdy=1.
2. Timeout: only n_in=11'h455 accepted at edge t, TIMEOUT=4, grp_rdy=1 -> grp_vld rises after edge t+4 with nty=11'h455, sty=ety=wty=0. grp_cnt=1 after the handshake.
3. Backpressure: full group launched with grp_rdy=0 for 5 cycles while all *_vld=1 with new flits -> outputs constant, all *_rdy=0, no new flit consumed. The handshake on cycle 6 is followed by acceptance of the new flits on cycle 7.
4. Port already filled: n accepted (11'h4AA), then n_vld=1 with 11'h4BB while s/e/w idle -> n_rdy=0 until launch. The launched nty=11'h4AA, and 11'h4BB is accepted after the handshake.
5. Null input: n_in=11'h0AA (bit10=0), n_vld=1 -> n_rdy=1, flit consumed, state stays IDLE, grp_vld stays 0.
6. Reset and wrap: assert rst_n=0 mid-LAUNCH -> grp_vld, nty..wty and grp_cnt go 0 without a clock edge. Then launch 256 full groups -> grp_cnt wraps to 0.
